// File: rtl/io_command_buffer.sv
// IO command buffer: queues core commands, issues them over IO_REQ/IO_ACK, and holds one register response.
// Optional zero-latency bypass when empty is enabled by defining IO_CMDBUF_BYPASS_EN.
module io_command_buffer #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int REG_W      = 4
) (
    input  logic                         clk,
    input  logic                         clk_en,
    input  logic                         sync_rst,
    input  logic                         Cmd_Valid,
    output logic                         Cmd_Ready,
    input  logic                         Cmd_CommandEn,
    input  logic                         Cmd_ResponseRequested,
    input  logic [REG_W-1:0]             Cmd_DestReg,
    input  logic [DATA_WIDTH-1:0]        Cmd_Data,
    output logic                         IO_REQ,
    input  logic                         IO_ACK,
    output logic                         IO_CommandEn,
    output logic                         IO_ResponseRequested,
    output logic [REG_W-1:0]             IO_DestRegOut,
    output logic [DATA_WIDTH-1:0]        IO_DataOut,
    input  logic                         IO_RegResponseFlag,
    input  logic                         IO_MemResponseFlag,
    input  logic [REG_W-1:0]             IO_DestRegIn,
    input  logic [DATA_WIDTH-1:0]        IO_DataIn,
    output logic                         WB_Valid,
    input  logic                         WB_Ready,
    output logic [REG_W-1:0]             WB_DestReg,
    output logic [DATA_WIDTH-1:0]        WB_Data,
    output logic [$clog2(DEPTH+1)-1:0]   Occupancy,
    output logic                         Err_Sticky
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {EMPTY, ISSUE, WAIT_WB} issueState_t;

    issueState_t state, nextState;

    logic                  cmdEnMem   [DEPTH];
    logic                  respReqMem [DEPTH];
    logic [REG_W-1:0]      destMem    [DEPTH];
    logic [DATA_WIDTH-1:0] dataMem    [DEPTH];

    logic [AW-1:0]         headPtr, tailPtr, nextHead;
    logic [CW-1:0]         count, nextCount;
    logic                  wbValid, nextWbValid;
    logic [REG_W-1:0]      wbDest;
    logic [DATA_WIDTH-1:0] wbData;
    logic                  errSticky;

    logic bypassActive, bypassTake, pushEn, popFifo, ioPop;
    logic wbLoad, wbDrain, respDrop, memErr, nextHeadRespReq;

    // Bypass is offered only when the command could issue immediately if it were the head.
`ifdef IO_CMDBUF_BYPASS_EN
    assign bypassActive = (count == '0) && (!wbValid || !Cmd_ResponseRequested);
`else
    assign bypassActive = 1'b0;
`endif

    assign Cmd_Ready  = (count != CW'(DEPTH));
    assign bypassTake = bypassActive && Cmd_Valid && IO_ACK && clk_en;
    assign pushEn     = Cmd_Valid && Cmd_Ready && clk_en && !bypassTake;
    assign popFifo    = (state == ISSUE) && IO_ACK && clk_en;
    assign ioPop      = popFifo || bypassTake;

    assign wbLoad   = ioPop && IO_RegResponseFlag && !wbValid;
    assign respDrop = ioPop && IO_RegResponseFlag && wbValid;
    assign memErr   = ioPop && IO_MemResponseFlag;
    assign wbDrain  = wbValid && WB_Ready && clk_en;

    always_comb begin
        IO_REQ               = (state == ISSUE);
        IO_CommandEn         = cmdEnMem[headPtr];
        IO_ResponseRequested = respReqMem[headPtr];
        IO_DestRegOut        = destMem[headPtr];
        IO_DataOut           = dataMem[headPtr];
        if (bypassActive) begin
            IO_REQ               = Cmd_Valid;
            IO_CommandEn         = Cmd_CommandEn;
            IO_ResponseRequested = Cmd_ResponseRequested;
            IO_DestRegOut        = Cmd_DestReg;
            IO_DataOut           = Cmd_Data;
        end
    end

    // Next-cycle bookkeeping; the push lands on the new head when the FIFO would otherwise be empty.
    always_comb begin
        nextHead  = popFifo ? headPtr + AW'(1) : headPtr;
        nextCount = count;
        case ({pushEn, popFifo})
            2'b10:   nextCount = count + CW'(1);
            2'b01:   nextCount = count - CW'(1);
            default: nextCount = count;
        endcase
        nextWbValid = wbValid;
        if (wbLoad)       nextWbValid = 1'b1;
        else if (wbDrain) nextWbValid = 1'b0;
        nextHeadRespReq = respReqMem[nextHead];
        if (pushEn && (tailPtr == nextHead)) nextHeadRespReq = Cmd_ResponseRequested;
    end

    always_comb begin
        nextState = ISSUE;
        if (nextCount == '0)                      nextState = EMPTY;
        else if (nextHeadRespReq && nextWbValid)  nextState = WAIT_WB;
    end

    always_ff @(posedge clk) begin
        if (!sync_rst)   state <= EMPTY;
        else if (clk_en) state <= nextState;
    end

    always_ff @(posedge clk) begin
        if (pushEn) begin
            cmdEnMem[tailPtr]   <= Cmd_CommandEn;
            respReqMem[tailPtr] <= Cmd_ResponseRequested;
            destMem[tailPtr]    <= Cmd_DestReg;
            dataMem[tailPtr]    <= Cmd_Data;
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_rst) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else if (clk_en) begin
            headPtr <= nextHead;
            if (pushEn) tailPtr <= tailPtr + AW'(1);
            count <= nextCount;
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_rst) begin
            wbValid   <= 1'b0;
            wbDest    <= '0;
            wbData    <= '0;
            errSticky <= 1'b0;
        end else if (clk_en) begin
            wbValid <= nextWbValid;
            if (wbLoad) begin
                wbDest <= IO_DestRegIn;
                wbData <= IO_DataIn;
            end
            if (respDrop || memErr) errSticky <= 1'b1;
        end
    end

    assign WB_Valid   = wbValid;
    assign WB_DestReg = wbDest;
    assign WB_Data    = wbData;
    assign Occupancy  = count;
    assign Err_Sticky = errSticky;

endmodule

// File: tb/tb_io_command_buffer.sv
// Directed self-checking bench for io_command_buffer (DEPTH=4, DATA_WIDTH=16, REG_W=4).
module tb_io_command_buffer;

    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int RW    = 4;

    logic          clk = 1'b0;
    logic          clk_en, sync_rst;
    logic          Cmd_Valid, Cmd_Ready, Cmd_CommandEn, Cmd_ResponseRequested;
    logic [RW-1:0] Cmd_DestReg;
    logic [DW-1:0] Cmd_Data;
    logic          IO_REQ, IO_ACK, IO_CommandEn, IO_ResponseRequested;
    logic [RW-1:0] IO_DestRegOut;
    logic [DW-1:0] IO_DataOut;
    logic          IO_RegResponseFlag, IO_MemResponseFlag;
    logic [RW-1:0] IO_DestRegIn;
    logic [DW-1:0] IO_DataIn;
    logic          WB_Valid, WB_Ready;
    logic [RW-1:0] WB_DestReg;
    logic [DW-1:0] WB_Data;
    logic [2:0]    Occupancy;
    logic          Err_Sticky;

    int nCompared   = 0;
    int nMismatched = 0;

    io_command_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .REG_W(RW)) dut (
        .clk(clk), .clk_en(clk_en), .sync_rst(sync_rst),
        .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_CommandEn(Cmd_CommandEn),
        .Cmd_ResponseRequested(Cmd_ResponseRequested), .Cmd_DestReg(Cmd_DestReg), .Cmd_Data(Cmd_Data),
        .IO_REQ(IO_REQ), .IO_ACK(IO_ACK), .IO_CommandEn(IO_CommandEn),
        .IO_ResponseRequested(IO_ResponseRequested), .IO_DestRegOut(IO_DestRegOut), .IO_DataOut(IO_DataOut),
        .IO_RegResponseFlag(IO_RegResponseFlag), .IO_MemResponseFlag(IO_MemResponseFlag),
        .IO_DestRegIn(IO_DestRegIn), .IO_DataIn(IO_DataIn),
        .WB_Valid(WB_Valid), .WB_Ready(WB_Ready), .WB_DestReg(WB_DestReg), .WB_Data(WB_Data),
        .Occupancy(Occupancy), .Err_Sticky(Err_Sticky)
    );

    always #5 clk = ~clk;

    task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are checked 2 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idleInputs();
        Cmd_Valid = 0; Cmd_CommandEn = 0; Cmd_ResponseRequested = 0; Cmd_DestReg = '0; Cmd_Data = '0;
        IO_ACK = 0; IO_RegResponseFlag = 0; IO_MemResponseFlag = 0; IO_DestRegIn = '0; IO_DataIn = '0;
        WB_Ready = 0;
    endtask

    task automatic pushCmd(input logic respReq, input logic [RW-1:0] dest, input logic [DW-1:0] data);
        Cmd_Valid = 1; Cmd_CommandEn = 1; Cmd_ResponseRequested = respReq;
        Cmd_DestReg = dest; Cmd_Data = data;
        tick();
        Cmd_Valid = 0; Cmd_ResponseRequested = 0;
    endtask

    task automatic applyReset();
        sync_rst = 0;
        tick();
        sync_rst = 1;
    endtask

    initial begin
        clk_en = 1; sync_rst = 0;
        idleInputs();
        tick(); tick();
        sync_rst = 1;
        settle();
        expectEq("rst_occ", Occupancy, 0);
        expectEq("rst_wbv", WB_Valid, 0);
        expectEq("rst_wbd", WB_DestReg, 0);
        expectEq("rst_wbdat", WB_Data, 0);
        expectEq("rst_err", Err_Sticky, 0);
        expectEq("rst_req", IO_REQ, 0);
        expectEq("rst_rdy", Cmd_Ready, 1);

`ifdef IO_CMDBUF_BYPASS_EN
        // Empty buffer: command passes straight through and is consumed without a FIFO write.
        Cmd_Valid = 1; Cmd_CommandEn = 1; Cmd_Data = 16'hE401; IO_ACK = 1;
        settle();
        expectEq("byp_req", IO_REQ, 1);
        expectEq("byp_data", IO_DataOut, 16'hE401);
        tick();
        Cmd_Valid = 0; IO_ACK = 0;
        settle();
        expectEq("byp_occ", Occupancy, 0);
        expectEq("byp_wbv", WB_Valid, 0);
`else
        // One-cycle latency from push to IO_REQ.
        Cmd_Valid = 1; Cmd_CommandEn = 1; Cmd_Data = 16'hE401; IO_ACK = 1;
        settle();
        expectEq("lat_req0", IO_REQ, 0);
        tick();
        Cmd_Valid = 0;
        settle();
        expectEq("lat_req1", IO_REQ, 1);
        expectEq("lat_data", IO_DataOut, 16'hE401);
        expectEq("lat_occ1", Occupancy, 1);
        tick();
        IO_ACK = 0;
        settle();
        expectEq("lat_occ0", Occupancy, 0);
        expectEq("lat_req_off", IO_REQ, 0);
        expectEq("lat_wbv", WB_Valid, 0);
`endif

        // Fill to DEPTH with the device stalled; pointers wrap along the way.
        for (int i = 0; i < 4; i++) begin
            Cmd_Valid = 1; Cmd_CommandEn = 1; Cmd_Data = 16'h1001 + 16'(i);
            settle();
            expectEq("fill_rdy", Cmd_Ready, 1);
            tick();
        end
        Cmd_Data = 16'h1005;
        settle();
        expectEq("full_rdy", Cmd_Ready, 0);
        expectEq("full_occ", Occupancy, 4);
        tick();
        settle();
        expectEq("full_hold", Occupancy, 4);
        IO_ACK = 1;
        settle();
        expectEq("full_head", IO_DataOut, 16'h1001);
        tick();
        IO_ACK = 0;
        settle();
        expectEq("pop_occ", Occupancy, 3);
        expectEq("pop_rdy", Cmd_Ready, 1);
        tick();
        Cmd_Valid = 0;
        settle();
        expectEq("refill_occ", Occupancy, 4);
        IO_ACK = 1;
        for (int j = 0; j < 4; j++) begin
            settle();
            expectEq("order_req", IO_REQ, 1);
            expectEq("order_data", IO_DataOut, 16'h1002 + 16'(j));
            tick();
        end
        IO_ACK = 0;
        settle();
        expectEq("drain_occ", Occupancy, 0);

        // Response capture and WAIT_WB stall.
        pushCmd(1, 4'd5, 16'h2001);
        pushCmd(1, 4'd6, 16'h2002);
        IO_ACK = 1; IO_RegResponseFlag = 1; IO_DestRegIn = 4'd3; IO_DataIn = 16'h00A5;
        settle();
        expectEq("resp_req", IO_REQ, 1);
        expectEq("resp_head", IO_DataOut, 16'h2001);
        expectEq("resp_dest", IO_DestRegOut, 5);
        tick();
        IO_ACK = 0; IO_RegResponseFlag = 0;
        settle();
        expectEq("wb_valid", WB_Valid, 1);
        expectEq("wb_dest", WB_DestReg, 3);
        expectEq("wb_data", WB_Data, 16'h00A5);
        expectEq("wait_req", IO_REQ, 0);
        expectEq("wait_head", IO_DataOut, 16'h2002);
        tick();
        WB_Ready = 1;
        settle();
        expectEq("wait_req_rdy", IO_REQ, 0);
        tick();
        WB_Ready = 0;
        settle();
        expectEq("wb_drained", WB_Valid, 0);
        expectEq("wait_release", IO_REQ, 1);

        // Clock enable low freezes everything.
        clk_en = 0; Cmd_Valid = 1; Cmd_CommandEn = 1; Cmd_Data = 16'h3000;
        IO_ACK = 1; IO_RegResponseFlag = 1; IO_DataIn = 16'h1234;
        for (int k = 0; k < 3; k++) begin
            tick();
            settle();
            expectEq("cen_occ", Occupancy, 1);
            expectEq("cen_wbv", WB_Valid, 0);
        end
        clk_en = 1; Cmd_Valid = 0; IO_ACK = 0; IO_RegResponseFlag = 0;
        settle();
        expectEq("cen_head", IO_DataOut, 16'h2002);

        // Load WB, queue three entries, then reset mid-operation.
        IO_ACK = 1; IO_RegResponseFlag = 1; IO_DestRegIn = 4'd7; IO_DataIn = 16'h0BEE;
        tick();
        IO_ACK = 0; IO_RegResponseFlag = 0;
        pushCmd(0, 4'd0, 16'h4001);
        pushCmd(0, 4'd0, 16'h4002);
        pushCmd(0, 4'd0, 16'h4003);
        settle();
        expectEq("pre_rst_occ", Occupancy, 3);
        expectEq("pre_rst_wbv", WB_Valid, 1);
        applyReset();
        settle();
        expectEq("mid_rst_occ", Occupancy, 0);
        expectEq("mid_rst_wbv", WB_Valid, 0);
        expectEq("mid_rst_req", IO_REQ, 0);
        expectEq("mid_rst_wbdat", WB_Data, 0);

        // Memory response on a pop is a sticky error.
        pushCmd(0, 4'd0, 16'h5001);
        IO_ACK = 1; IO_MemResponseFlag = 1;
        tick();
        IO_ACK = 0; IO_MemResponseFlag = 0;
        settle();
        expectEq("err_set", Err_Sticky, 1);
        tick(); tick();
        settle();
        expectEq("err_hold", Err_Sticky, 1);
        applyReset();
        settle();
        expectEq("err_clr", Err_Sticky, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/io_command_buffer.md
Name: io_command_buffer

Overview:
- Upstream neighbour of the GPIO controller and other IO devices on the shared IO command bus.
- Accepts IO commands from the core over a valid/ready port and queues them in a DEPTH-entry FIFO.
- Issues queued commands to the device with the IO_REQ/IO_ACK handshake.
- Captures register-bound responses into a single writeback holding register drained by the core's writeback stage.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- DATA_WIDTH, 16: command and response data width.
- REG_W, 4: destination register index width.

Ports:
- clk  in  1  sole clock.
- clk_en  in  1  global enable; when 0, no state updates.
- sync_rst  in  1  reset. One clock; reset is synchronous and active-low (0 = reset).
- Cmd_Valid  in  1  core presents a command.
- Cmd_Ready  out  1  buffer accepts a command.
- Cmd_CommandEn  in  1  command (vs. no-op) flag.
- Cmd_ResponseRequested  in  1  a register response is wanted.
- Cmd_DestReg  in  REG_W  response destination register.
- Cmd_Data  in  DATA_WIDTH  command word: [15:13] addr, [12:10] op.
- IO_REQ  out  1  head entry presented to device.
- IO_ACK  in  1  device accepts the head this cycle.
- IO_CommandEn  out  1  head CommandEn.
- IO_ResponseRequested  out  1  head ResponseRequested.
- IO_DestRegOut  out  REG_W  head DestReg.
- IO_DataOut  out  DATA_WIDTH  head Data.
- IO_RegResponseFlag  in  1  device returns register data this cycle.
- IO_MemResponseFlag  in  1  unsupported; must be 0.
- IO_DestRegIn  in  REG_W  returned destination register.
- IO_DataIn  in  DATA_WIDTH  returned data.
- WB_Valid  out  1  writeback register holds a response.
- WB_Ready  in  1  writeback stage consumes.
- WB_DestReg  out  REG_W  response destination.
- WB_Data  out  DATA_WIDTH  response data.
- Occupancy  out  $clog2(DEPTH+1)  FIFO entry count.
- Err_Sticky  out  1  protocol error seen.

Behaviour:
- Reset: FIFO flushed (ptrs=0, Occupancy=0), WB_Valid=0, WB_DestReg=0, WB_Data=0, Err_Sticky=0, IO_REQ=0, Cmd_Ready=1 the cycle after reset releases. Reset mid-operation discards all queued entries and any held response.
- All updates are gated by clk_en. When clk_en=0, state holds and outputs stay stable.
- Push: Cmd_Valid && Cmd_Ready && clk_en writes the tail. Cmd_Ready = (Occupancy != DEPTH); there is no full-with-pop pass-through.
- Issue FSM, derived from occupancy and WB state:
  - EMPTY: IO_REQ=0.
  - ISSUE: Occupancy>0 and (!WB_Valid or head ResponseRequested=0); IO_REQ=1.
  - WAIT_WB: head ResponseRequested=1 and WB_Valid=1; IO_REQ=0 until WB drains.
  - IO_REQ depends only on registered state, never on WB_Ready.
- Pop: IO_REQ && IO_ACK && clk_en advances the head. IO_* head fields come straight from FIFO storage.
- Latency: with no bypass, a command pushed in cycle N first appears on IO_REQ in cycle N+1.
- Simultaneous push and pop with 0<Occupancy<DEPTH: Occupancy unchanged. Pointers wrap modulo DEPTH.
- Response capture: on a pop cycle with IO_RegResponseFlag=1, register IO_DestRegIn/IO_DataIn and set WB_Valid the next cycle. Flags are sampled only on pop cycles.
- WB drain: WB_Valid && WB_Ready && clk_en clears WB_Valid. Drain and load cannot coincide because of WAIT_WB gating.
- Error cases, each setting Err_Sticky (cleared only by reset):
  - IO_RegResponseFlag=1 while WB_Valid=1: response dropped.
  - IO_MemResponseFlag=1 on a pop cycle.

Optional Feature:
- Macro IO_CMDBUF_BYPASS_EN.
- Defined: when Occupancy=0 and the issue FSM would otherwise be in ISSUE, the Cmd_* inputs drive the IO_* outputs combinationally with IO_REQ=Cmd_Valid. If IO_ACK is seen the same cycle, the command is consumed without a FIFO write (zero latency). Otherwise it is written to the FIFO normally.
- Undefined: no bypass; minimum one-cycle latency as above.

Test Plan:
- Reset, then push 0xE401 (addr 7, op 1) with ResponseRequested=0 and IO_ACK held 1 -> IO_REQ=1 one cycle later with IO_DataOut=0xE401; Occupancy goes 1 then 0; WB_Valid stays 0.
- Push 5 commands with IO_ACK=0, DEPTH=4 -> Cmd_Ready=0 after the 4th push; 5th held until one pop; entries issue in order (FIFO integrity across wrap).
- Head ResponseRequested=1, device returns DestReg=3, Data=0x00A5, WB_Ready=0 -> WB_Valid=1 with WB_DestReg=3, WB_Data=0x00A5. A second response-requesting head sits in WAIT_WB with IO_REQ=0 until WB_Ready=1 drains, then issues.
- clk_en=0 for 3 cycles with Cmd_Valid=1 and IO_ACK=1 -> Occupancy, WB and pointers unchanged.
- sync_rst=0 for one cycle with Occupancy=3 and WB_Valid=1 -> next cycle Occupancy=0, WB_Valid=0, IO_REQ=0.
- IO_MemResponseFlag=1 on a pop -> Err_Sticky=1 until reset. With IO_CMDBUF_BYPASS_EN defined, empty buffer, Cmd_Valid=1, IO_ACK=1 -> IO_REQ=1 the same cycle and Occupancy stays 0.
